// File: rtl/bcd2bin_pkg.sv
// Shared types and helpers for the ASCII digit-string to binary converter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        DONE
    } state_t;

    localparam logic [4:0] INVALID_DIGIT = 5'd16;

    // Map one ASCII hex character to its digit value; anything else is INVALID_DIGIT.
    function automatic logic [4:0] ascii2dig(input logic [7:0] ch);
        logic [4:0] dig;
        dig = INVALID_DIGIT;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            dig = 5'(ch - 8'h30);
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            dig = 5'(ch - 8'h61) + 5'd10;
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            dig = 5'(ch - 8'h41) + 5'd10;
        end
        return dig;
    endfunction

endpackage

// File: rtl/bcd2bin.sv
// Weighted accumulator: acc <= (clr ? 0 : acc) + bcd * wgt when nd is set, modulo 2^BB.
module bcd2bin #(
    parameter int BB = 32,
    parameter int MB = 29
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          nd_i,
    input  logic [3:0]    bcd_i,
    input  logic [MB-1:0] wgt_i,
    output logic [BB-1:0] q_o
);

    logic [MB+3:0] prod;
    logic [BB-1:0] term;
    logic [BB-1:0] acc;

    always_comb begin
        prod = (MB+4)'(wgt_i) * (MB+4)'(bcd_i);
        term = BB'(prod);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc <= '0;
        end else if (clr_i) begin
            acc <= nd_i ? term : '0;
        end else if (nd_i) begin
            acc <= acc + term;
        end
    end

    assign q_o = acc;

endmodule

// File: rtl/bcd2bin_seq.sv
// Collects an MSB-first ASCII digit string into a LIFO, then pops LSB-first
// into the bcd2bin accumulator with weights radix^k.
module bcd2bin_seq
    import bcd2bin_pkg::*;
#(
    parameter int BB    = 32,
    parameter int MB    = 29,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [4:0]    radix_i,
    input  logic          ch_valid_i,
    output logic          ch_ready_o,
    input  logic [7:0]    ch_data_i,
    input  logic          ch_last_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [BB-1:0] res_data_o,
    output logic          res_err_o
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [MB-1:0] WGT_ONE = MB'(1);

    state_t        state;
    logic [3:0]    mem [DEPTH];
    logic [AW:0]   count;
    logic [MB-1:0] weight;
    logic [4:0]    radix_q;
    logic          err;
    logic          started;
    logic          first;
    logic          ready_q;
    logic          valid_q;

    logic [4:0]    dig;
    logic [4:0]    eff_radix;
    logic          accept;
    logic          push;
    logic [AW:0]   top_idx;
    logic [3:0]    top;
    logic [MB+4:0] wprod;
    logic          clr;
    logic          nd;

    always_comb begin
        dig       = ascii2dig(ch_data_i);
        // The first character of a string is judged against the live radix input
        eff_radix = started ? radix_q : radix_i;
        accept    = ch_valid_i && ready_q;
        push      = accept && (dig < eff_radix) && (count < DEPTH_C);
        top_idx   = count - CNT_ONE;
        top       = mem[top_idx[AW-1:0]];
        wprod     = (MB+5)'(weight) * (MB+5)'(radix_q);
        clr       = (state == CONVERT) && first;
        nd        = (state == CONVERT) && (count != '0);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[count[AW-1:0]] <= dig[3:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= COLLECT;
            count   <= '0;
            weight  <= WGT_ONE;
            radix_q <= 5'd2;
            err     <= 1'b0;
            started <= 1'b0;
            first   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (!started) begin
                            started <= 1'b1;
                            radix_q <= radix_i;
                        end
                        if (push) begin
                            count <= count + CNT_ONE;
                        end else begin
                            err <= 1'b1;
                        end
                        if (ch_last_i) begin
                            state   <= CONVERT;
                            weight  <= WGT_ONE;
                            first   <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                CONVERT: begin
                    first <= 1'b0;
                    if (count == '0) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        count  <= count - CNT_ONE;
                        weight <= wprod[MB-1:0];
                        // Weight overflow only matters if another digit still needs it
                        if ((|wprod[MB+4:MB]) && (count > CNT_ONE)) begin
                            err <= 1'b1;
                        end
                        if (count == CNT_ONE) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state   <= COLLECT;
                        err     <= 1'b0;
                        started <= 1'b0;
                        weight  <= WGT_ONE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    bcd2bin #(
        .BB(BB),
        .MB(MB)
    ) u_acc (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (clr),
        .nd_i  (nd),
        .bcd_i (top),
        .wgt_i (weight),
        .q_o   (res_data_o)
    );

    assign ch_ready_o  = ready_q;
    assign res_valid_o = valid_q;
    assign res_err_o   = valid_q && err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq with immediate-assertion checks.
module tb_bcd2bin_seq;

    logic        clk;
    logic        rst_n;
    logic [4:0]  radix;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  ch_data;
    logic        ch_last;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;

    int n_assert = 0;
    int n_fail   = 0;

    bcd2bin_seq #(
        .BB   (32),
        .MB   (29),
        .DEPTH(8),
        .AW   (3)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .radix_i    (radix),
        .ch_valid_i (ch_valid),
        .ch_ready_o (ch_ready),
        .ch_data_i  (ch_data),
        .ch_last_i  (ch_last),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .res_data_o (res_data),
        .res_err_o  (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Later characters see radix 2 on the input, so the string must rely on the latched radix.
    task automatic send_string(input string s, input logic [4:0] r);
        for (int i = 0; i < s.len(); i++) begin
            radix    = (i == 0) ? r : 5'd2;
            ch_valid = 1'b1;
            ch_data  = s[i];
            ch_last  = (i == s.len() - 1);
            @(posedge clk);
            #1;
            ch_valid = 1'b0;
            ch_last  = 1'b0;
        end
    endtask

    task automatic get_result(input string tag, input int exp_edges,
                              input logic [31:0] exp_data, input logic exp_err,
                              input int hold);
        int edges;
        edges = 0;
        while (!res_valid && edges < 30) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_err"}, {31'd0, res_err}, {31'd0, exp_err});
        check({tag, "_chready_busy"}, {31'd0, ch_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
            check({tag, "_hold_data"}, res_data, exp_data);
            check({tag, "_hold_chready"}, {31'd0, ch_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_chready_back"}, {31'd0, ch_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        radix     = 5'd10;
        ch_valid  = 1'b0;
        ch_data   = 8'h00;
        ch_last   = 1'b0;
        res_ready = 1'b0;
        #12;
        check("rst_chready", {31'd0, ch_ready}, 32'd1);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_err", {31'd0, res_err}, 32'd0);
        check("rst_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_string("1234", 5'd10);
        get_result("dec1234", 4, 32'h0000_04D2, 1'b0, 0);

        send_string("fF", 5'd16);
        get_result("hexff", 2, 32'd255, 1'b0, 0);

        send_string("1011", 5'd2);
        get_result("bin1011", 4, 32'd11, 1'b0, 0);

        send_string("192", 5'd8);
        get_result("oct_bad", 2, 32'd10, 1'b1, 0);

        send_string("123456789", 5'd10);
        get_result("overfill", 8, 32'd12345678, 1'b1, 0);

        send_string("z", 5'd10);
        get_result("empty", 1, 32'd0, 1'b1, 0);

        send_string("89abcdef", 5'd16);
        get_result("hex8", 8, 32'h89AB_CDEF, 1'b0, 5);

        send_string("7", 5'd10);
        get_result("seven", 1, 32'd7, 1'b0, 0);

        send_string("987", 5'd10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_chready", {31'd0, ch_ready}, 32'd1);
        check("midrst_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_err", {31'd0, res_err}, 32'd0);
        check("midrst_data", res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_string("42", 5'd10);
        get_result("post_rst", 2, 32'd42, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
